// File: rtl/ram_burst_pkg.sv
// Shared types and constants for the RAM burst reader and its output buffer.
package ram_burst_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_e;

  localparam int BufDepth = 2;
  localparam int OccW     = $clog2(BufDepth + 1);

endpackage

// File: rtl/ram_skid_fifo.sv
// Two-entry FIFO with valid/ready on both sides; the head register drives the
// output directly so out_data/out_valid are flop outputs.
module ram_skid_fifo
  import ram_burst_pkg::*;
#(
  parameter int W = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [OccW-1:0] occ
);

  logic [W-1:0]    head_q, head_d;
  logic [W-1:0]    tail_q, tail_d;
  logic [OccW-1:0] count_q, count_d;
  logic            push, pop;

  assign out_valid = (count_q != '0);
  assign out_data  = head_q;
  assign occ       = count_q;
  // A full buffer can still take a word when the head leaves in the same cycle.
  assign in_ready  = (count_q != OccW'(BufDepth)) || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == '0) head_d = in_data;
        else               tail_d = in_data;
        count_d = count_q + OccW'(1);
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - OccW'(1);
      end
      2'b11: begin
        if (count_q == OccW'(1)) begin
          head_d = in_data;
        end else begin
          head_d = tail_q;
          tail_d = in_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ram_burst_reader.sv
// Burst read master: walks a wrapping address range on the RAM read port and
// streams the returned words out with valid/ready and a last-beat flag.
module ram_burst_reader
  import ram_burst_pkg::*;
#(
  parameter int Width     = 8,
  parameter int Depth     = 16,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AddrWidth-1:0] baseAddr,
  input  logic [AddrWidth:0]   len,
  output logic                 busy,
  output logic                 done,
  output logic [AddrWidth-1:0] rdAddr,
  input  logic [Width-1:0]     rdData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [Width-1:0]     outData,
  output logic                 outLast
);

  localparam int CntW = AddrWidth + 1;
  localparam int SumW = OccW + 1;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] rd_addr_q, rd_addr_d;
  logic [CntW-1:0]      len_q, len_d;
  logic [CntW-1:0]      issued_q, issued_d;
  logic [CntW-1:0]      delivered_q, delivered_d;
  logic                 tag_q, tag_d;
  logic                 tag_last_q, tag_last_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 fifo_in_ready;
  logic                 fifo_valid;
  logic [Width:0]       fifo_out;
  logic [OccW-1:0]      fifo_occ;

  logic                 pop, room, issue, last_issue, last_pop;
  logic [AddrWidth-1:0] addr_next;

  assign pop        = fifo_valid && outReady;
  // Words buffered plus words still coming back from the RAM must stay within
  // the buffer, otherwise a stalled consumer would force a returning word out.
  assign room       = ({1'b0, fifo_occ} + SumW'(tag_q)) < (SumW'(BufDepth) + SumW'(pop));
  assign issue      = (state_q == READ) && room && fifo_in_ready;
  assign last_issue = (issued_q + CntW'(1)) == len_q;
  assign last_pop   = pop && ((delivered_q + CntW'(1)) == len_q);
  assign addr_next  = (rd_addr_q == AddrWidth'(Depth - 1)) ? '0 : rd_addr_q + AddrWidth'(1);

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    tag_d       = 1'b0;
    tag_last_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d     = READ;
            busy_d      = 1'b1;
            len_d       = len;
            rd_addr_d   = baseAddr;
            issued_d    = '0;
            delivered_d = '0;
          end
        end
      end
      READ: begin
        if (issue) begin
          tag_d      = 1'b1;
          tag_last_d = last_issue;
          rd_addr_d  = addr_next;
          issued_d   = issued_q + CntW'(1);
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: ;
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && pop) delivered_d = delivered_q + CntW'(1);
    if (state_q != IDLE && last_pop) begin
      state_d = IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_addr_q   <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      tag_q       <= 1'b0;
      tag_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      tag_q       <= tag_d;
      tag_last_q  <= tag_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  ram_skid_fifo #(
    .W(Width + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_valid (tag_q),
    .in_ready (fifo_in_ready),
    .in_data  ({tag_last_q, rdData}),
    .out_valid(fifo_valid),
    .out_ready(outReady),
    .out_data (fifo_out),
    .occ      (fifo_occ)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdAddr   = rd_addr_q;
  assign outValid = fifo_valid;
  assign outData  = fifo_out[Width-1:0];
  assign outLast  = fifo_out[Width];

endmodule

// File: doc/ram_burst_reader.md
Name: ram_burst_reader

Overview:
- Read-side master for the single-port-write / single-port-read `ram` block.
- On `start`, it walks a contiguous, wrapping address range and drives `rdAddr`. It captures `rdData` and presents the words as a valid/ready stream with a last-beat flag.
- It sits between the RAM read port and any downstream consumer, and absorbs backpressure without losing in-flight reads.

Parameters:
- Width, 8, data word width; must match the RAM's Width.
- Depth, 16, RAM depth in words; must match the RAM's Depth.
- AddrWidth, $clog2(Depth), address width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a burst; sampled only in IDLE.
- baseAddr  input  AddrWidth  first address of the burst; sampled with start.
- len  input  AddrWidth+1  number of words, 0..Depth; sampled with start.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the burst completes.
- rdAddr  output  AddrWidth  read address to the RAM; registered.
- rdData  input  Width  RAM read data; valid one cycle after rdAddr is presented (registered read).
- outValid  output  1  stream word valid.
- outReady  input  1  consumer accepts the word when outValid && outReady.
- outData  output  Width  stream word.
- outLast  output  1  high with the final word of the burst.

Behaviour:
- Reset values: busy=0, done=0, rdAddr=0, outValid=0, outData=0, outLast=0. Buffer, counters and the in-flight tag are cleared, and FSM goes to IDLE.
- Reset mid-burst aborts immediately. In-flight reads are discarded, no done pulse is produced, and rdData arriving after reset is ignored.
- FSM states:
  - IDLE: accepts start.
  - READ: issuing addresses.
  - DRAIN: all addresses issued; emptying the buffer.
- IDLE -> READ: start=1 and len!=0. baseAddr and len are latched, and busy rises the next cycle.
- IDLE with start=1, len=0: no reads issued. done pulses the next cycle, busy stays 0, and FSM stays in IDLE.
- start while busy is ignored; latched parameters are unaffected.
- Issue rule: a read is "issued" in a cycle when the FSM is in READ and (buffer occupancy + in-flight count − pop this cycle) < 2.
  - On issue, the next address is presented and a 1-bit in-flight tag is pipelined to mark the returning rdData cycle.
  - rdAddr holds its value when no read is issued.
- Addresses run baseAddr, baseAddr+1, … modulo Depth. Wrap from Depth−1 to 0 is required; when Depth is not a power of two, the address wraps explicitly at Depth−1.
- READ -> DRAIN once len reads are issued.
- DRAIN -> IDLE after the last word is handshaken. done pulses exactly one cycle later, and busy falls in that same cycle.
- Output buffer:
  - 2-entry FIFO; outData/outValid/outLast come from the head register.
  - Tagged rdData is written at the edge following its arrival cycle.
- Output timing:
  - Start accepted at edge E0; first rdAddr=baseAddr after E0; rdData valid after E1; buffered at E2.
  - outValid rises after E2, a latency of 2 cycles from start.
  - With outReady held high, throughput is 1 word/cycle with no bubbles.
- Backpressure: while outValid && !outReady, outData and outLast stay stable and outValid stays high. Issue pauses so that occupancy plus in-flight never exceeds 2.
- outLast=1 only on beat number len. outValid drops after the last handshake unless a new burst begins.
- Simultaneous push and pop on the buffer is legal; occupancy is unchanged.
- Counters (issued, delivered) are AddrWidth+1 bits so that len=Depth is representable.

Decomposition:
- Package ram_burst_pkg holds:
  - FSM state enum (IDLE, READ, DRAIN).
  - Constant BufDepth=2.
- One natural sub-module: ram_skid_fifo, a 2-entry FIFO with valid/ready on both sides, parameterised by Width+1 (data plus last flag).

Test Plan:
- Preload RAM addr i with i*2 (i=0..9). start, baseAddr=0, len=10, outReady=1 -> outData 0,2,…,18 on 10 consecutive cycles; outValid first high 2 cycles after start; outLast only on 18; done one cycle after.
- Wrap: Depth=16, RAM addr i = i+0x40, baseAddr=14, len=4 -> rdAddr sequence 14,15,0,1; outData 0x4E,0x4F,0x40,0x41.
- Backpressure: len=6, outReady toggles 1,0,0,1,… -> no word lost or duplicated, outData stable while stalled, and occupancy never exceeds 2 (assertion).
- len=0 and start-while-busy: start with len=0 -> done pulse, no outValid. Start during a burst -> ignored; original burst completes unchanged.
- Reset mid-burst: assert rst after 3 beats -> all outputs 0 immediately. A new start, baseAddr=5, len=2, then returns RAM words 5 and 6 only, with no stale data.
- len=Depth (16), baseAddr=3 -> 16 beats covering every address once, ending at address 2 with outLast.
